// File: rtl/pipe_pkg.sv
// Shared definitions for the ARM fetch/decode/execute pipeline sequencer.
package pipe_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FILL1 = 2'd1,
        S_FILL2 = 2'd2,
        S_RUN   = 2'd3
    } pipe_state_e;

    localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Three-stage pipeline sequencer: refills after reset/PC writes and decides
// commit / skip / hold for the execute-stage instruction each cycle.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cond_fail,
    input  logic             exec_busy,
    input  logic             pc_write,
    input  logic             mem_wait,
    output logic             fetch_en,
    output logic             pc_load,
    output logic             dec_valid,
    output logic             exe_valid,
    output logic             exe_commit,
    output logic [CNT_W-1:0] skip_cnt
);

    pipe_state_e state;
    logic        hold;
    logic        adv;
    logic        flush;
    logic        skip;

    // A failed condition masks busy and pc_write: it always costs one cycle.
    assign hold       = exe_valid & ~cond_fail & exec_busy;
    assign adv        = ~mem_wait & ~hold;
    assign exe_commit = ~mem_wait & exe_valid & ~cond_fail & ~exec_busy;
    assign flush      = exe_commit & pc_write;
    assign skip       = ~mem_wait & exe_valid & cond_fail;

    assign pc_load  = ~mem_wait & ((state == S_RESET) | flush);
    assign fetch_en = adv & (state != S_RESET) & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RESET;
            dec_valid <= 1'b0;
            exe_valid <= 1'b0;
        end else if (!mem_wait) begin
            if (flush) begin
                state     <= S_FILL1;
                dec_valid <= 1'b0;
                exe_valid <= 1'b0;
            end else if (!hold) begin
                unique case (state)
                    S_RESET: begin
                        state     <= S_FILL1;
                        dec_valid <= 1'b0;
                        exe_valid <= 1'b0;
                    end
                    S_FILL1: begin
                        state     <= S_FILL2;
                        dec_valid <= 1'b1;
                    end
                    S_FILL2: begin
                        state     <= S_RUN;
                        exe_valid <= 1'b1;
                    end
                    default: state <= S_RUN;
                endcase
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_skip_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (skip),
        .count (skip_cnt)
    );

endmodule
